// File: rtl/candidate_buffer_pkg.sv
// rtl/candidate_buffer_pkg.sv - shared state type and helpers for the candidate delay buffer
package candidate_buffer_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      PRIMED  = 2'd2
   } state_e;

   // A delay of 0 has no tap, and no tap exists beyond the last physical stage.
   function automatic int unsigned clamp_delay(input int unsigned sel, input int unsigned depth);
      if (sel == 0) return 1;
      if (sel > depth) return depth;
      return sel;
   endfunction

   function automatic int unsigned ch_lo(input int unsigned ch, input int unsigned width);
      return ch * width;
   endfunction

endpackage

// File: rtl/candidate_shift_chain.sv
// rtl/candidate_shift_chain.sv - one channel of qualified shift stages with a selectable tap
module candidate_shift_chain #(
   parameter int DATAWIDTH = 8,
   parameter int DEPTH     = 10,
   parameter int SELW      = $clog2(DEPTH + 1)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 shift,
   input  logic                 clear,
   input  logic [DATAWIDTH-1:0] din,
   input  logic [SELW-1:0]      tap_sel,
   output logic [DATAWIDTH-1:0] dout
);

   logic [DATAWIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else if (shift) begin
         stage_q[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   // tap_sel counts beats of delay, so stage index is tap_sel-1.
   always_comb begin
      dout = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (tap_sel == SELW'(i + 1)) dout = stage_q[i];
      end
   end

endmodule

// File: rtl/candidate_delay_buffer.sv
// rtl/candidate_delay_buffer.sv - multi-channel equal-delay candidate line with fill tracking and flush
module candidate_delay_buffer
   import candidate_buffer_pkg::*;
#(
   parameter  int DATAWIDTH = 8,
   parameter  int NUM_CH    = 9,
   parameter  int DEPTH     = 10,
   localparam int CNTW      = $clog2(DEPTH + 1)
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        in_valid,
   input  logic                        flush,
   input  logic [CNTW-1:0]             delay_sel,
   input  logic [NUM_CH*DATAWIDTH-1:0] in_data,
   output logic [NUM_CH*DATAWIDTH-1:0] out_data,
   output logic                        out_valid,
   output logic [CNTW-1:0]             fill_level,
   output logic [CNTW-1:0]             cfg_delay
);

   state_e          state_q, state_d;
   logic [CNTW-1:0] fill_q, fill_d;
   logic [CNTW-1:0] cfg_q, cfg_d;
   logic            accept;

   // Flush wins over a coincident beat, which is then neither stored nor counted.
   assign accept = in_valid & ~flush;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= EMPTY;
         fill_q  <= '0;
         cfg_q   <= CNTW'(DEPTH);
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         cfg_q   <= cfg_d;
      end
   end

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      cfg_d   = cfg_q;
      if (flush) begin
         state_d = EMPTY;
         fill_d  = '0;
         cfg_d   = CNTW'(clamp_delay(32'(delay_sel), DEPTH));
      end else if (accept) begin
         if (fill_q != CNTW'(DEPTH)) fill_d = fill_q + CNTW'(1);
         case (state_q)
            EMPTY:   state_d = (cfg_q == CNTW'(1)) ? PRIMED : FILLING;
            FILLING: if (fill_q + CNTW'(1) == cfg_q) state_d = PRIMED;
            default: state_d = state_q;
         endcase
      end
   end

   assign out_valid  = (state_q == PRIMED);
   assign fill_level = fill_q;
   assign cfg_delay  = cfg_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam int unsigned LO = ch_lo(c, DATAWIDTH);

      candidate_shift_chain #(
         .DATAWIDTH (DATAWIDTH),
         .DEPTH     (DEPTH),
         .SELW      (CNTW)
      ) u_chain (
         .clock   (clock),
         .reset   (reset),
         .shift   (accept),
         .clear   (flush),
         .din     (in_data[LO +: DATAWIDTH]),
         .tap_sel (cfg_q),
         .dout    (out_data[LO +: DATAWIDTH])
      );
   end

endmodule

// File: doc/candidate_delay_buffer.md
Name: candidate_delay_buffer

Overview:
Parametrised successor to the fixed 9-channel, 10-stage candidate buffer. It is a multi-channel, equal-delay shift line with a runtime-selectable tap depth, in_valid-qualified shifting, fill tracking and a synchronous flush. It sits between candidate generation and the SAD/compare stage, and out_valid tells downstream when the tap holds genuine candidates rather than reset or flush residue.

Parameters:
DATAWIDTH, 8, bits per candidate sample
NUM_CH, 9, number of parallel candidate channels
DEPTH, 10, number of physical stages per channel; maximum selectable delay
CNTW, $clog2(DEPTH+1), width of fill and delay fields (derived, not overridden)

Ports:
clock  in  1  single clock; all state updates on its rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  beat qualifier; the line shifts only when high (replaces the old enable)
flush  in  1  synchronous clear of fill state and stages; loads new delay
delay_sel  in  CNTW  requested delay in beats; sampled only on flush
in_data  in  NUM_CH*DATAWIDTH  channel c occupies bits [c*DATAWIDTH +: DATAWIDTH]
out_data  out  NUM_CH*DATAWIDTH  tap output per channel, same packing
out_valid  out  1  high while the tap holds a sample accepted since the last flush/reset
fill_level  out  CNTW  accepted beats since flush/reset, saturating at DEPTH
cfg_delay  out  CNTW  delay currently in force

Behaviour:
- Reset (reset low, async): all stages 0; fill_level 0; cfg_delay = DEPTH; state EMPTY; out_data 0; out_valid 0.
- Storage: per channel, stage[0..DEPTH-1].
- Accepted beat (in_valid=1, flush=0): stage[0] <= in_data, stage[i] <= stage[i-1]. No shift when in_valid=0; all state holds.
- Tap: out_data = stage[cfg_delay-1] per channel. This is a combinational mux from registers.
- Latency: a sample accepted on beat k appears on out_data after beat k+cfg_delay-1 is accepted, i.e. exactly cfg_delay accepted beats. Idle cycles do not age data.
- With cfg_delay = DEPTH = 10, the block behaves identically to the legacy 10-stage buffer clocked by enable.
- fill_level: +1 per accepted beat, saturating at DEPTH. It never wraps.
- FSM, registered:
  - EMPTY (fill=0) -> FILLING on an accepted beat if cfg_delay>1, or -> PRIMED directly if cfg_delay=1.
  - FILLING -> PRIMED on the accepted beat that makes fill = cfg_delay.
  - PRIMED holds until flush.
  - Any state -> EMPTY on flush.
- out_valid = (state==PRIMED). It is glitch-free, decoded from registers only.
- Flush (synchronous, level, 1 cycle):
  - Zeros all stages and sets fill_level <= 0.
  - Sets cfg_delay <= clamp(delay_sel): 0 -> 1, >DEPTH -> DEPTH.
  - out_valid is low from the next cycle.
- flush and in_valid in the same cycle: flush wins and the beat is dropped (not counted, not stored).
- delay_sel changes without flush are ignored. The tap never moves mid-stream.
- Reset mid-operation: immediate async clear to reset values. cfg_delay returns to DEPTH, not to the last programmed value.
- Flush held for multiple cycles: each cycle re-clears and reloads cfg_delay; no beats are accepted.

Decomposition:
- Package candidate_buffer_pkg:
  - state enum {EMPTY, FILLING, PRIMED}
  - function clamp_delay(sel, depth)
  - pack/unpack helpers for channel slices
- Sub-module candidate_shift_chain: one channel with DATAWIDTH and DEPTH parameters. It has inputs clock/reset/shift/clear/din/tap_sel and output dout.
- Top level instantiates NUM_CH chains with a generate loop and holds the FSM, fill counter and cfg_delay register.

Test Plan:
- Reset value check: drive in_valid=1 with random data during reset -> out_data all 0, out_valid 0, fill_level 0, cfg_delay 10.
- Default delay: NUM_CH=9, DEPTH=10; feed channel c = 8'h10*beat+c for beats 1..12 contiguous -> out_valid rises after beat 10; out_data ch3 = 8'h13 then; fill_level sticks at 10.
- Gapped input: the same stream with in_valid toggling 1,0,0,1... -> out_data sequence is identical per accepted beat and unchanged across idle cycles; out_valid rises only on the 10th accepted beat.
- Reprogram delay: flush with delay_sel=3, then feed 0xA1, 0xA2, 0xA3, 0xA4 on ch0 -> out_valid after the 3rd beat with out ch0 = 0xA1; after the 4th, 0xA2; cfg_delay=3.
- Clamping: flush with delay_sel=0 -> cfg_delay=1 and out_valid after the first beat with out = that beat. Flush with delay_sel=15 -> cfg_delay=10.
- Collision and mid-reset: flush with in_valid=1 and data 0xFF -> beat dropped, fill 0, out 0. Assert reset low while PRIMED with cfg_delay=3 -> immediate clear, cfg_delay back to 10.
